// File: rtl/ram_bus_pkg.sv
// Shared definitions for the RAM bus master: widths, op codes, FSM states,
// register-bank addresses and the CPU request payload.
package ram_bus_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;

  // Register banks occupy the top of the RAM; A doubles as the accumulator.
  localparam logic [ADDR_W-1:0] REG_A = ADDR_W'(63);
  localparam logic [ADDR_W-1:0] REG_B = ADDR_W'(62);
  localparam logic [ADDR_W-1:0] REG_C = ADDR_W'(61);
  localparam logic [ADDR_W-1:0] REG_D = ADDR_W'(60);
  localparam logic [ADDR_W-1:0] ACC_ADDR_DEF = REG_A;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_MOVE    = 2'b10,
    OP_ACC_ADD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_RD2,
    ST_WR,
    ST_RESP
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] src;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_bus_master_if.sv
// CPU request/response handshake plus the RAM initiator port.
//   master : the bus master (drives req_ready, rsp_*, ram_* except ram_rdata)
//   slave  : CPU/RAM side (drives req_*, rsp_ready, ram_rdata)
interface ram_bus_master_if;
  import ram_bus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_src;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_carry;

  logic              ram_read;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    input  req_valid, req_op, req_addr, req_src, req_wdata, rsp_ready, ram_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_carry,
           ram_read, ram_write, ram_addr, ram_wdata
  );

  modport slave (
    output req_valid, req_op, req_addr, req_src, req_wdata, rsp_ready, ram_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_carry,
           ram_read, ram_write, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_bus_master.sv
// Initiator for the 64x16 register-bank RAM. Accepts one CPU request
// (READ/WRITE/MOVE/ACC_ADD), sequences the RAM accesses and returns one
// response. All outputs are registered; RAM outputs never depend
// combinationally on the request inputs.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : ram_bus_master_if.master (CPU handshake + RAM port)
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ACC_ADDR = ACC_ADDR_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  ram_bus_master_if.master bus
);

  state_e            state, state_n;
  op_e               op_q, op_n;
  logic [ADDR_W-1:0] dst_q, dst_n;
  logic [DATA_W-1:0] opnd_q, opnd_n;
  logic              carry_q, carry_n;

  logic              req_ready_q, req_ready_n;
  logic              rsp_valid_q, rsp_valid_n;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_n;
  logic              rsp_carry_q, rsp_carry_n;
  logic              ram_read_q, ram_read_n;
  logic              ram_write_q, ram_write_n;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_n;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_n;

  req_t              req_c;
  logic [DATA_W:0]   sum_c;

  // Incoming request payload, only consulted on the accept edge.
  assign req_c = '{op: op_e'(bus.req_op), addr: bus.req_addr,
                   src: bus.req_src, wdata: bus.req_wdata};

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= OP_READ;
      dst_q       <= '0;
      opnd_q      <= '0;
      carry_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state       <= state_n;
      op_q        <= op_n;
      dst_q       <= dst_n;
      opnd_q      <= opnd_n;
      carry_q     <= carry_n;
      req_ready_q <= req_ready_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
      rsp_carry_q <= rsp_carry_n;
      ram_read_q  <= ram_read_n;
      ram_write_q <= ram_write_n;
      ram_addr_q  <= ram_addr_n;
      ram_wdata_q <= ram_wdata_n;
    end
  end

  // Next state and next-cycle output values.
  always_comb begin
    state_n     = state;
    op_n        = op_q;
    dst_n       = dst_q;
    opnd_n      = opnd_q;
    carry_n     = carry_q;
    req_ready_n = 1'b0;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data_q;
    rsp_carry_n = rsp_carry_q;
    ram_read_n  = 1'b0;
    ram_write_n = 1'b0;
    ram_addr_n  = ram_addr_q;
    ram_wdata_n = ram_wdata_q;
    sum_c       = (DATA_W+1)'(opnd_q) + (DATA_W+1)'(bus.ram_rdata);

    case (state)
      ST_IDLE: begin
        req_ready_n = 1'b1;
        if (bus.req_valid) begin
          req_ready_n = 1'b0;
          op_n        = req_c.op;
          dst_n       = req_c.addr;
          case (req_c.op)
            OP_WRITE: begin
              state_n     = ST_WR;
              ram_write_n = 1'b1;
              ram_addr_n  = req_c.addr;
              ram_wdata_n = req_c.wdata;
            end
            OP_MOVE: begin
              state_n    = ST_RD1;
              ram_read_n = 1'b1;
              ram_addr_n = req_c.src;
            end
            default: begin
              state_n    = ST_RD1;
              ram_read_n = 1'b1;
              ram_addr_n = req_c.addr;
            end
          endcase
        end
      end

      ST_RD1: begin
        opnd_n = bus.ram_rdata;
        case (op_q)
          OP_MOVE: begin
            state_n     = ST_WR;
            ram_write_n = 1'b1;
            ram_addr_n  = dst_q;
            ram_wdata_n = bus.ram_rdata;
          end
          OP_ACC_ADD: begin
            state_n    = ST_RD2;
            ram_read_n = 1'b1;
            ram_addr_n = ACC_ADDR;
          end
          default: begin
            state_n     = ST_RESP;
            rsp_valid_n = 1'b1;
            rsp_data_n  = bus.ram_rdata;
            rsp_carry_n = 1'b0;
          end
        endcase
      end

      // Operand was captured in RD1; accumulator is on ram_rdata now.
      ST_RD2: begin
        state_n     = ST_WR;
        ram_write_n = 1'b1;
        ram_addr_n  = ACC_ADDR;
        ram_wdata_n = sum_c[DATA_W-1:0];
        carry_n     = sum_c[DATA_W];
      end

      ST_WR: begin
        state_n     = ST_RESP;
        rsp_valid_n = 1'b1;
        rsp_data_n  = ram_wdata_q;
        rsp_carry_n = (op_q == OP_ACC_ADD) & carry_q;
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_n     = ST_IDLE;
          req_ready_n = 1'b1;
        end else begin
          rsp_valid_n = 1'b1;
        end
      end

      default: begin
        state_n     = ST_IDLE;
        req_ready_n = 1'b1;
      end
    endcase
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.ram_read  = ram_read_q;
  assign bus.ram_write = ram_write_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: behavioural 64x16 RAM responder, directed
// scenarios and a randomized run against an array-based reference model.
module tb_ram_bus_master;
  import ram_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ram_bus_master_if bus ();

  ram_bus_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM responder: async read while ram_read, write on posedge.
  logic [DATA_W-1:0] mem [64];
  assign bus.ram_rdata = bus.ram_read ? mem[bus.ram_addr] : 16'hA5A5;
  always @(posedge clk) if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_wdata;

  logic [DATA_W-1:0] ref_mem [64];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request and return #1 after the edge that accepts it.
  task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                      input logic [ADDR_W-1:0] src, input logic [DATA_W-1:0] wdata);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_src   = src;
    bus.req_wdata = wdata;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Model the op, then check latency, response, hold behaviour and handshake.
  task automatic expect_rsp(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                            input logic [ADDR_W-1:0] src, input logic [DATA_W-1:0] wdata,
                            input int hold);
    logic [DATA_W:0]   full;
    logic [DATA_W-1:0] ed;
    logic              ec;
    int                el;
    int                k;
    ec = 1'b0;
    case (op)
      OP_READ: begin
        ed = ref_mem[addr];
        el = 2;
      end
      OP_WRITE: begin
        ref_mem[addr] = wdata;
        ed = wdata;
        el = 2;
      end
      OP_MOVE: begin
        ed = ref_mem[src];
        ref_mem[addr] = ed;
        el = 3;
      end
      default: begin
        full = 17'(ref_mem[addr]) + 17'(ref_mem[REG_A]);
        ed = full[DATA_W-1:0];
        ec = full[DATA_W];
        ref_mem[REG_A] = ed;
        el = 4;
      end
    endcase
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      chk("rw_exclusive", 32'(bus.ram_read & bus.ram_write), 32'd0);
      if (bus.rsp_valid) break;
      chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      k++;
    end
    chk("latency", 32'(k + 1), 32'(el));
    chk("rsp_data", 32'(bus.rsp_data), 32'(ed));
    chk("rsp_carry", 32'(bus.rsp_carry), 32'(ec));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_data", 32'(bus.rsp_data), 32'(ed));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_ram_idle", 32'(bus.ram_read | bus.ram_write), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input logic [ADDR_W-1:0] src, input logic [DATA_W-1:0] wdata,
                        input int hold);
    send(op, addr, src, wdata);
    expect_rsp(op, addr, src, wdata, hold);
  endtask

  initial begin
    logic [1:0]        rop;
    logic [ADDR_W-1:0] ra, rs;
    logic [DATA_W-1:0] rw;
    int                rh;

    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_addr  = '0;
    bus.req_src   = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_carry", 32'(bus.rsp_carry), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_ram_rw", 32'({bus.ram_read, bus.ram_write}), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the RAM through the master so model and RAM start identical.
    for (int a = 0; a < 64; a++) run_op(OP_WRITE, 6'(a), 6'd0, 16'($urandom), 0);

    // WRITE then READ back
    run_op(OP_WRITE, 6'd5, 6'd0, 16'hBEEF, 0);
    run_op(OP_READ, 6'd5, 6'd0, 16'h0, 0);
    chk("t1_mem5", 32'(mem[5]), 32'h0000BEEF);

    // ACC_ADD with carry out
    run_op(OP_WRITE, REG_A, 6'd0, 16'hFFFF, 0);
    run_op(OP_WRITE, 6'd10, 6'd0, 16'h0002, 0);
    run_op(OP_ACC_ADD, 6'd10, 6'd0, 16'h0, 0);
    chk("t2_acc", 32'(mem[63]), 32'h00000001);

    // MOVE B -> C
    run_op(OP_WRITE, REG_B, 6'd0, 16'h1234, 0);
    run_op(OP_MOVE, REG_C, REG_B, 16'h0, 0);
    chk("t3_dst", 32'(mem[61]), 32'h00001234);
    chk("t3_src", 32'(mem[62]), 32'h00001234);

    // Stalled response with a request held pending behind it
    send(OP_WRITE, 6'd7, 6'd0, 16'h4321);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_READ;
    bus.req_addr  = 6'd7;
    expect_rsp(OP_WRITE, 6'd7, 6'd0, 16'h4321, 5);
    @(negedge clk);
    chk("held_idle_ready", 32'(bus.req_ready), 32'd1);
    chk("held_not_started", 32'(bus.ram_read), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    expect_rsp(OP_READ, 6'd7, 6'd0, 16'h0, 0);

    // Reset during the RD2 cycle of ACC_ADD
    run_op(OP_WRITE, REG_A, 6'd0, 16'h0007, 0);
    run_op(OP_WRITE, 6'd10, 6'd0, 16'h0003, 0);
    send(OP_ACC_ADD, 6'd10, 6'd0, 16'h0);
    @(posedge clk);
    #1;
    chk("rd2_addr", 32'({bus.ram_read, bus.ram_addr}), 32'({1'b1, REG_A}));
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_rsp", 32'({bus.rsp_valid, bus.rsp_carry, bus.rsp_data}), 32'd0);
    chk("abort_ram_ctl", 32'({bus.ram_read, bus.ram_write, bus.ram_addr}), 32'd0);
    chk("abort_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    chk("abort_acc_kept", 32'(mem[63]), 32'h00000007);

    // Corners: doubling ACC, self MOVE, address extremes
    run_op(OP_ACC_ADD, REG_A, 6'd0, 16'h0, 0);
    chk("acc_double", 32'(mem[63]), 32'h0000000E);
    run_op(OP_MOVE, 6'd0, 6'd0, 16'h0, 0);
    run_op(OP_WRITE, 6'd0, 6'd0, 16'h8001, 0);
    run_op(OP_READ, 6'd0, 6'd0, 16'h0, 0);
    run_op(OP_WRITE, 6'd63, 6'd0, 16'h7FFE, 0);
    run_op(OP_READ, 6'd63, 6'd0, 16'h0, 1);

    // Randomized traffic
    for (int n = 0; n < 10000; n++) begin
      rop = 2'($urandom);
      ra  = 6'($urandom_range(0, 63));
      rs  = 6'($urandom_range(0, 63));
      rw  = 16'($urandom);
      rh  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(rop, ra, rs, rw, rh);
    end

    for (int a = 0; a < 64; a++) chk("final_mem", 32'(mem[a]), 32'(ref_mem[a]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
